// File: rtl/alu_transfer_sequencer_if.sv
// Control bundle between the instruction source and the ALU transfer sequencer.
// The master side issues instructions and memory status; the slave side drives the datapath strobes.
interface alu_transfer_sequencer_if;
    logic        start;
    logic [4:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic        mem_ready;

    logic [31:0] src_out;
    logic [15:0] reg_in;
    logic        mar_in;
    logic        pc_in;
    logic        ir_in;
    logic        mdr_in;
    logic        y_in;
    logic        z_in;
    logic        hi_in;
    logic        lo_in;
    logic        read;
    logic        inc_pc;
    logic [4:0]  alu_op;
    logic        busy;
    logic        done;

    modport master (
        output start, op, ra, rb, rc, mem_ready,
        input  src_out, reg_in, mar_in, pc_in, ir_in, mdr_in, y_in, z_in,
               hi_in, lo_in, read, inc_pc, alu_op, busy, done
    );

    modport slave (
        input  start, op, ra, rb, rc, mem_ready,
        output src_out, reg_in, mar_in, pc_in, ir_in, mdr_in, y_in, z_in,
               hi_in, lo_in, read, inc_pc, alu_op, busy, done
    );
endinterface

// File: rtl/alu_transfer_sequencer.sv
// Control-step sequencer for register-to-register ALU instructions: fetch (T0-T2), execute (T3-T6).
// All strobes are Moore outputs decoded from the registered step and the captured instruction fields.
module alu_transfer_sequencer #(
    parameter logic [4:0] OP_MUL = 5'b01110,
    parameter logic [4:0] OP_DIV = 5'b01111,
    parameter logic [4:0] OP_NEG = 5'b10000,
    parameter logic [4:0] OP_NOT = 5'b10001
) (
    input  logic                      clock,
    input  logic                      clear,
    alu_transfer_sequencer_if.slave   bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
    } state_t;

    localparam int SRC_ZHI = 18;
    localparam int SRC_ZLO = 19;
    localparam int SRC_PC  = 20;
    localparam int SRC_MDR = 21;

    state_t      state;
    state_t      state_next;
    logic [4:0]  op_q;
    logic [3:0]  ra_q;
    logic [3:0]  rb_q;
    logic [3:0]  rc_q;
    logic        is_unary;
    logic        is_muldiv;

    logic [31:0] src;
    logic [15:0] reg_en;
    logic        mar_en, pc_en, ir_en, mdr_en, y_en, z_en, hi_en, lo_en;
    logic        read_en, inc_en, busy_en, done_en;
    logic [4:0]  alu_sel;

    assign is_unary  = (op_q == OP_NEG) || (op_q == OP_NOT);
    assign is_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (clear) begin
            state <= S_IDLE;
            op_q  <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rc_q  <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && bus.start) begin
                op_q <= bus.op;
                ra_q <= bus.ra;
                rb_q <= bus.rb;
                rc_q <= bus.rc;
            end
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            S_IDLE:  if (bus.start) state_next = S_T0;
            S_T0:    state_next = S_T1;
            S_T1:    state_next = S_T1W;
            S_T1W:   if (bus.mem_ready) state_next = S_T2;
            S_T2:    state_next = is_unary ? S_T4 : S_T3;
            S_T3:    state_next = S_T4;
            S_T4:    state_next = S_T5;
            S_T5:    state_next = is_muldiv ? S_T6 : S_DONE;
            S_T6:    state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        src     = '0;
        reg_en  = '0;
        mar_en  = 1'b0;
        pc_en   = 1'b0;
        ir_en   = 1'b0;
        mdr_en  = 1'b0;
        y_en    = 1'b0;
        z_en    = 1'b0;
        hi_en   = 1'b0;
        lo_en   = 1'b0;
        read_en = 1'b0;
        inc_en  = 1'b0;
        alu_sel = '0;
        busy_en = (state != S_IDLE);
        done_en = 1'b0;
        case (state)
            S_T0: begin
                src[SRC_PC] = 1'b1;
                mar_en      = 1'b1;
                inc_en      = 1'b1;
                z_en        = 1'b1;
            end
            S_T1: begin
                src[SRC_ZLO] = 1'b1;
                pc_en        = 1'b1;
            end
            S_T1W: begin
                read_en = 1'b1;
                mdr_en  = 1'b1;
            end
            S_T2: begin
                src[SRC_MDR] = 1'b1;
                ir_en        = 1'b1;
            end
            S_T3: begin
                src[{1'b0, rb_q}] = 1'b1;
                y_en              = 1'b1;
            end
            S_T4: begin
                // Unary ops have no Y operand, so Rb rides the bus straight into the ALU.
                src[{1'b0, (is_unary ? rb_q : rc_q)}] = 1'b1;
                z_en    = 1'b1;
                alu_sel = op_q;
            end
            S_T5: begin
                src[SRC_ZLO] = 1'b1;
                if (is_muldiv) lo_en = 1'b1;
                else           reg_en[ra_q] = 1'b1;
            end
            S_T6: begin
                src[SRC_ZHI] = 1'b1;
                hi_en        = 1'b1;
            end
            S_DONE:  done_en = 1'b1;
            default: ;
        endcase
    end

    assign bus.src_out = src;
    assign bus.reg_in  = reg_en;
    assign bus.mar_in  = mar_en;
    assign bus.pc_in   = pc_en;
    assign bus.ir_in   = ir_en;
    assign bus.mdr_in  = mdr_en;
    assign bus.y_in    = y_en;
    assign bus.z_in    = z_en;
    assign bus.hi_in   = hi_en;
    assign bus.lo_in   = lo_en;
    assign bus.read    = read_en;
    assign bus.inc_pc  = inc_en;
    assign bus.alu_op  = alu_sel;
    assign bus.busy    = busy_en;
    assign bus.done    = done_en;

endmodule

// File: tb/tb_alu_transfer_sequencer.sv
// Self-checking bench: a step-list model of each instruction's control sequence is compared
// against every sequencer output on every falling clock edge.
module tb_alu_transfer_sequencer;

    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10001;

    // Enable vector order: {mar, pc, ir, mdr, y, z, hi, lo, read, inc_pc}
    localparam logic [9:0] E_MAR  = 10'b1000000000;
    localparam logic [9:0] E_PC   = 10'b0100000000;
    localparam logic [9:0] E_IR   = 10'b0010000000;
    localparam logic [9:0] E_MDR  = 10'b0001000000;
    localparam logic [9:0] E_Y    = 10'b0000100000;
    localparam logic [9:0] E_Z    = 10'b0000010000;
    localparam logic [9:0] E_HI   = 10'b0000001000;
    localparam logic [9:0] E_LO   = 10'b0000000100;
    localparam logic [9:0] E_READ = 10'b0000000010;
    localparam logic [9:0] E_INC  = 10'b0000000001;

    typedef struct packed {
        logic [31:0] src;
        logic [15:0] reg_in;
        logic [9:0]  en;
        logic [4:0]  alu_op;
        logic        busy;
        logic        done;
    } exp_t;

    logic clock;
    logic clear;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   run_check = 1'b0;
    exp_t exp_q[$];

    alu_transfer_sequencer_if bus ();

    alu_transfer_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] bus_bit(input int i);
        logic [31:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic void push_step(input logic [31:0] s, input logic [15:0] r,
                                      input logic [9:0] e, input logic [4:0] a, input logic d);
        exp_t x;
        x.src    = s;
        x.reg_in = r;
        x.en     = e;
        x.alu_op = a;
        x.busy   = 1'b1;
        x.done   = d;
        exp_q.push_back(x);
    endfunction

    // The instruction's control steps, one entry per clock, written from the transfer list.
    function automatic void build_expected(input logic [4:0] o, input logic [3:0] a,
                                           input logic [3:0] b, input logic [3:0] c, input int waits);
        bit unary;
        bit muldiv;
        logic [15:0] dest;
        unary  = (o == OP_NEG) || (o == OP_NOT);
        muldiv = (o == OP_MUL) || (o == OP_DIV);
        dest   = '0;
        dest[a] = 1'b1;
        push_step(bus_bit(20), '0, E_MAR | E_INC | E_Z, '0, 1'b0);
        push_step(bus_bit(19), '0, E_PC, '0, 1'b0);
        for (int i = 0; i <= waits; i++) push_step('0, '0, E_READ | E_MDR, '0, 1'b0);
        push_step(bus_bit(21), '0, E_IR, '0, 1'b0);
        if (!unary) push_step(bus_bit(int'(b)), '0, E_Y, '0, 1'b0);
        push_step(bus_bit(unary ? int'(b) : int'(c)), '0, E_Z, o, 1'b0);
        if (muldiv) begin
            push_step(bus_bit(19), '0, E_LO, '0, 1'b0);
            push_step(bus_bit(18), '0, E_HI, '0, 1'b0);
        end else begin
            push_step(bus_bit(19), dest, '0, '0, 1'b0);
        end
        push_step('0, '0, '0, '0, 1'b1);
    endfunction

    function automatic exp_t observe();
        exp_t v;
        v.src    = bus.src_out;
        v.reg_in = bus.reg_in;
        v.en     = {bus.mar_in, bus.pc_in, bus.ir_in, bus.mdr_in, bus.y_in,
                    bus.z_in, bus.hi_in, bus.lo_in, bus.read, bus.inc_pc};
        v.alu_op = bus.alu_op;
        v.busy   = bus.busy;
        v.done   = bus.done;
        return v;
    endfunction

    // Outside an instruction the model expects every output at zero.
    always @(negedge clock) begin
        if (run_check) begin
            exp_t e;
            e = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            check("cycle_outputs", 96'(observe()), 96'(e));
        end
    end

    task automatic run_instr(input logic [4:0] o, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input int waits, input int glitch_cyc,
                             input int exp_done);
        int cyc;
        bit seen;
        @(posedge clock); #1;
        bus.start = 1'b1;
        bus.op    = o;
        bus.ra    = a;
        bus.rb    = b;
        bus.rc    = c;
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.op    = ~o;
        bus.ra    = ~a;
        bus.rb    = ~b;
        bus.rc    = ~c;
        build_expected(o, a, b, c, waits);
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= 40) begin
            bus.start     = (cyc == glitch_cyc);
            if (cyc == glitch_cyc) bus.rc = c + 4'd1;
            bus.mem_ready = (cyc >= 3 + waits);
            @(negedge clock);
            if (bus.done === 1'b1) seen = 1'b1;
            else begin
                @(posedge clock); #1;
                cyc++;
            end
        end
        check("done_cycle", 96'(cyc), 96'(exp_done));
        bus.start     = 1'b0;
        bus.mem_ready = 1'b1;
    endtask

    initial begin
        clear         = 1'b1;
        bus.start     = 1'b1;
        bus.op        = 5'd3;
        bus.ra        = 4'd1;
        bus.rb        = 4'd2;
        bus.rc        = 4'd3;
        bus.mem_ready = 1'b1;
        run_check     = 1'b1;

        // Clear held two cycles with start high: nothing may begin.
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 96'(bus.busy), 96'(0));
        check("rst_done", 96'(bus.done), 96'(0));
        check("rst_src", 96'(bus.src_out), 96'(0));
        clear     = 1'b0;
        bus.start = 1'b0;
        @(posedge clock); #1;
        check("rst_no_t0", 96'(bus.busy), 96'(0));

        // Pin the model against hand-derived steps before trusting it.
        build_expected(5'b00011, 4'd3, 4'd4, 4'd5, 0);
        check("pin_add_len", 96'(exp_q.size()), 96'(8));
        check("pin_add_t0", 96'(exp_q[0].src), 96'(32'h0010_0000));
        check("pin_add_t3", 96'({exp_q[4].src, exp_q[4].en}), 96'({32'h0000_0010, E_Y}));
        check("pin_add_t4", 96'({exp_q[5].src, exp_q[5].alu_op}), 96'({32'h0000_0020, 5'd3}));
        check("pin_add_t5", 96'({exp_q[6].src, exp_q[6].reg_in}), 96'({32'h0008_0000, 16'h0008}));
        exp_q.delete();
        build_expected(OP_MUL, 4'd1, 4'd6, 4'd7, 0);
        check("pin_mul_len", 96'(exp_q.size()), 96'(9));
        check("pin_mul_t5", 96'({exp_q[6].src, exp_q[6].en}), 96'({32'h0008_0000, E_LO}));
        check("pin_mul_t6", 96'({exp_q[7].src, exp_q[7].en}), 96'({32'h0004_0000, E_HI}));
        exp_q.delete();
        build_expected(OP_NEG, 4'd9, 4'd2, 4'd11, 0);
        check("pin_neg_len", 96'(exp_q.size()), 96'(7));
        check("pin_neg_t4", 96'(exp_q[4].src), 96'(32'h0000_0004));
        check("pin_neg_t5", 96'(exp_q[5].reg_in), 96'(16'h0200));
        exp_q.delete();
        build_expected(5'b00100, 4'd1, 4'd2, 4'd3, 3);
        check("pin_wait_len", 96'(exp_q.size()), 96'(11));
        exp_q.delete();

        run_instr(5'b00011, 4'd3, 4'd4, 4'd5, 0, 0, 8);
        run_instr(OP_MUL, 4'd1, 4'd6, 4'd7, 0, 0, 9);
        run_instr(OP_NEG, 4'd9, 4'd2, 4'd11, 0, 0, 7);
        run_instr(5'b00100, 4'd1, 4'd2, 4'd3, 3, 0, 11);
        run_instr(5'b00101, 4'd7, 4'd8, 4'd10, 0, 5, 8);
        run_instr(OP_DIV, 4'd15, 4'd14, 4'd13, 0, 0, 9);
        run_instr(OP_NOT, 4'd12, 4'd12, 4'd12, 0, 0, 7);
        run_instr(5'b11111, 4'd0, 4'd15, 4'd0, 0, 0, 8);

        // Clear in the middle of a stalled memory read.
        @(posedge clock); #1;
        bus.start     = 1'b1;
        bus.op        = 5'b00011;
        bus.ra        = 4'd2;
        bus.rb        = 4'd3;
        bus.rc        = 4'd4;
        bus.mem_ready = 1'b0;
        @(posedge clock); #1;
        bus.start = 1'b0;
        build_expected(5'b00011, 4'd2, 4'd3, 4'd4, 10);
        repeat (3) @(posedge clock);
        #1;
        check("clr_in_t1w", 96'(bus.read), 96'(1));
        clear = 1'b1;
        @(posedge clock); #1;
        exp_q.delete();
        clear         = 1'b0;
        bus.mem_ready = 1'b1;
        check("clr_busy", 96'(bus.busy), 96'(0));
        check("clr_read", 96'(bus.read), 96'(0));
        check("clr_src", 96'(bus.src_out), 96'(0));

        run_instr(5'b00110, 4'd5, 4'd6, 4'd1, 0, 0, 8);

        repeat (2) @(posedge clock);
        #1;
        run_check = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_transfer_sequencer.md
Name: alu_transfer_sequencer

Overview:
Control-step sequencer for register-to-register ALU instructions on the shared 32-bit bus. It drives the one-hot source-select vector feeding the 32:5 bus encoder and the register-load enables, following these control steps: fetch (T0–T2), then execute (T3–T6). The sequencer sits between the testbench or future control unit (start/op/register fields) and the datapath. It owns all bus-source and register-in strobes for the duration of one instruction.

Parameters:
OP_MUL, 5'b01110, opcode for multiply (writes LO then HI)
OP_DIV, 5'b01111, opcode for divide (writes LO then HI)
OP_NEG, 5'b10000, unary opcode (no Y load, Rb is the sole operand)
OP_NOT, 5'b10001, unary opcode (no Y load, Rb is the sole operand)

Ports:
clock  in  1  system clock, rising edge
clear  in  1  synchronous active-high reset
start  in  1  begin instruction; sampled only in IDLE
op  in  5  ALU opcode; captured on accepted start
ra  in  4  destination register index; captured on accepted start
rb  in  4  first source register index; captured on accepted start
rc  in  4  second source register index; captured on accepted start
mem_ready  in  1  memory read data valid
src_out  out  32  one-hot bus source: bits 0–15 = R0–R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C, 24–31 unused (always 0)
reg_in  out  16  R0–R15 load enables
mar_in, pc_in, ir_in, mdr_in, y_in, z_in, hi_in, lo_in  out  1 each  register load enables
read  out  1  memory read request
inc_pc  out  1  ALU performs PC+1 instead of op
alu_op  out  5  opcode to ALU; valid in T4 (and T0 via inc_pc)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on completion

Behaviour:
- Synchronous active-high clear on clock: state=IDLE, captured fields=0, and every output 0.
- All outputs are Moore, decoded from registered state and captured fields.
- At most one src_out bit is high in any cycle. src_out=0 in IDLE, T1W and DONE.
- States and per-state outputs:
  - IDLE: if start, capture op/ra/rb/rc and go to T0; otherwise stay.
  - T0: src_out[20] (PC), mar_in, inc_pc, z_in; go to T1.
  - T1: src_out[19] (ZLO), pc_in; go to T1W.
  - T1W: read, mdr_in. Hold while mem_ready=0. On mem_ready=1 in the same cycle, go to T2.
  - T2: src_out[21] (MDR), ir_in. Go to T4 if op is NEG or NOT, else T3.
  - T3: src_out[rb], y_in; go to T4.
  - T4: z_in, alu_op=op. Bus source is src_out[rb] for NEG/NOT, else src_out[rc]. Go to T5.
  - T5: src_out[19] (ZLO). For MUL/DIV: lo_in, go to T6. Otherwise: reg_in[ra], go to DONE.
  - T6: src_out[18] (ZHI), hi_in; go to DONE.
  - DONE: done=1, busy=1; go to IDLE.
- alu_op=0 outside T4.
- Latency with mem_ready already high:
  - binary op: 8 cycles (T0 through DONE)
  - unary op: 7 cycles
  - MUL/DIV: 9 cycles
  - each extra cycle of mem_ready low adds one cycle.
- start outside IDLE is ignored. Captured fields are stable for the whole instruction.
- Input changes to op/ra/rb/rc while busy have no effect.
- clear in any state, including T1W mid-read, takes priority over all transitions. Outputs are 0 on the next cycle.
- rb=rc=ra is legal; no hazard logic is required.
- Opcodes other than those named take the binary-op path.

Test Plan:
- Reset: clear high 2 cycles with start=1 → busy=0, done=0, src_out=0, all enables 0; no T0 entered.
- ADD op=5'b00011, ra=3, rb=4, rc=5, mem_ready=1 → in successive cycles:
  - src_out=0x00100000 (PC); then 0x00080000 (ZLO)
  - read for 1 cycle
  - 0x00200000 (MDR), then 0x00000010 (R4) with y_in
  - 0x00000020 (R5) with z_in and alu_op=3
  - 0x00080000 with reg_in=0x0008
  - done pulses 8 cycles after start acceptance.
- MUL op=OP_MUL, rb=6, rc=7 → T5 lo_in with src_out=0x00080000, T6 hi_in with src_out=0x00040000; reg_in never nonzero; done at cycle 9.
- NEG rb=2, ra=9 → y_in never asserted; T4 src_out=0x00000004; reg_in=0x0200 in T5; done at cycle 7.
- mem_ready held low 3 cycles in T1W → read and mdr_in high 4 cycles total, src_out=0 throughout; T2 follows the mem_ready=1 cycle; done at cycle 11.
- Robustness:
  - start pulsed during T3 → ignored; captured rc unchanged.
  - clear asserted during T1W → next cycle IDLE with all outputs 0; fresh start is accepted afterwards.
